avalon_mm_rr_arbiter: RTL
=========================

// Module: avalon_mm_rr_arbiter
// PURPOSE
// Shares one Avalon-MM slave port between NUM_MASTERS Avalon-MM masters using round-robin arbitration.
// Each master uses waitrequest-based transfers with no readdatavalid:
//   - a read or write completes in the cycle where the slave deasserts waitrequest.
// The arbiter sits between the master drivers/BFMs and a single slave; it does not pipeline transfers.
// It also flags slaves that stall too long (waitrequest watchdog).
// PARAMETERS
// NUM_MASTERS  4    number of requesting masters (2..8)
// AW           32   address width
// DW           32   data width
// TIMEOUT      256  stall-watchdog limit in cycles; 0 disables the watchdog
// PORTS
// clk              in   1               single clock, all logic on posedge
// reset            in   1               synchronous, active-high
// m_address        in   NUM_MASTERS*AW  master addresses, master i at [i*AW +: AW]
// m_read           in   NUM_MASTERS     read requests
// m_write          in   NUM_MASTERS     write requests
// m_writedata      in   NUM_MASTERS*DW  write data, packed like m_address
// m_readdata       out  DW              slave readdata broadcast to all masters
// m_waitrequest    out  NUM_MASTERS     per-master waitrequest
// s_address        out  AW              to slave
// s_read           out  1               to slave
// s_write          out  1               to slave
// s_writedata      out  DW              to slave
// s_readdata       in   DW              from slave
// s_waitrequest    in   1               from slave
// grant            out  NUM_MASTERS     one-hot current grant, all-zero when idle
// timeout_err      out  1               sticky; set on watchdog expiry
// timeout_clr      in   1               clears timeout_err
// BEHAVIOUR
// - Reset (synchronous, active-high): state=IDLE, grant=0, last_grant=master NUM_MASTERS-1 (so master 0 wins first), stall_cnt=0, timeout_err=0.
//   Outputs while in IDLE: s_read=0, s_write=0, m_waitrequest=all ones.
// - Request definition: req[i] = m_read[i] | m_write[i]. Masters with read and write both high are protocol violations; read takes priority.
// - IDLE state:
//   - If any req is high, pick the first requester scanning upward from last_grant+1, modulo NUM_MASTERS.
//   - Register the one-hot grant and go to BUSY. Requester sees its grant one cycle after raising req (1-cycle arbitration latency).
// - BUSY state, granted master g:
//   - s_address/s_writedata/s_read/s_write are combinational muxes of master g's signals.
//   - m_waitrequest[g] = s_waitrequest. All other m_waitrequest bits stay 1.
//   - m_readdata = s_readdata, combinational, all states.
// - Completion: (s_read|s_write) && !s_waitrequest in BUSY.
//   - last_grant <= g.
//   - Re-arbitrate the same cycle over req with bit g masked. A winner gives a back-to-back grant in BUSY with no idle bubble; no winner returns to IDLE.
//   - Master g therefore cannot win two consecutive grants while any other master is requesting.
// - Request drop: if master g drops req in BUSY without completing, it is an abort. Go to IDLE; last_grant is unchanged; no error flagged.
// - Watchdog, when TIMEOUT>0:
//   - stall_cnt counts BUSY cycles with s_waitrequest=1. It clears on completion, abort, or new grant, and saturates at TIMEOUT.
//   - When stall_cnt reaches TIMEOUT, timeout_err is set. The grant is retained; the transfer cannot be aborted by the arbiter.
// - timeout_err clearing: timeout_clr clears it. A set and a clear in the same cycle resolve to set.
// - Reset mid-transfer: the grant is dropped immediately at the next posedge. s_read/s_write deassert; the slave must tolerate this.
// - Grant invariants: grant is always one-hot or zero. Arbitration is fully combinational from req/last_grant; no priority inversion.
// TESTING
// 1. Reset, then m_write[2]=1 addr=0x10 data=0xA5, slave waitrequest low immediately -> grant=0100 next cycle; s_write=1, s_address=0x10, s_writedata=0xA5; m_waitrequest[2]=0 in that cycle; back to IDLE.
// 2. All 4 masters read continuously, slave waitrequest=1 for 2 cycles per transfer -> grants cycle 0,1,2,3,0 with no IDLE gap between them; each m_readdata sampled when own waitrequest low.
// 3. Masters 1 and 3 request, last_grant=3 -> master 1 granted first, then 3. Master 1 re-raises during master 3's transfer -> master 1 next.
// 4. TIMEOUT=8, slave holds waitrequest=1 for 20 cycles -> timeout_err rises on stall cycle 8 and stays high. Grant is unchanged; pulse timeout_clr in cycle 12 -> timeout_err stays set, since the watchdog is saturated and stalling.
// 5. Master 0 granted, drops m_read while waitrequest=1 -> IDLE next cycle, s_read=0, grant=0, no timeout_err.
// 6. Assert reset during BUSY with s_waitrequest=1 -> next cycle grant=0, s_read=s_write=0, all m_waitrequest=1, timeout_err=0.

Source files
------------

// File: rtl/avalon_mm_rr_arbiter_if.sv
// Avalon-MM bus bundle shared by NUM_MASTERS masters and one slave.
// The "slave" modport is the arbiter's view: it is the slave of the masters
// and drives the downstream slave port. The "master" modport is the
// environment's view: master drivers plus the downstream slave model.
interface avalon_mm_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS*AW-1:0] m_address;
  logic [NUM_MASTERS-1:0]    m_read;
  logic [NUM_MASTERS-1:0]    m_write;
  logic [NUM_MASTERS*DW-1:0] m_writedata;
  logic [DW-1:0]             m_readdata;
  logic [NUM_MASTERS-1:0]    m_waitrequest;
  logic [AW-1:0]             s_address;
  logic                      s_read;
  logic                      s_write;
  logic [DW-1:0]             s_writedata;
  logic [DW-1:0]             s_readdata;
  logic                      s_waitrequest;

  modport slave (
    input  m_address, m_read, m_write, m_writedata, s_readdata, s_waitrequest,
    output m_readdata, m_waitrequest, s_address, s_read, s_write, s_writedata
  );

  modport master (
    output m_address, m_read, m_write, m_writedata, s_readdata, s_waitrequest,
    input  m_readdata, m_waitrequest, s_address, s_read, s_write, s_writedata
  );
endinterface

// File: rtl/avalon_mm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between NUM_MASTERS
// waitrequest-only masters, with a sticky stall watchdog.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; slave strobes low, all masters see waitrequest
//   BUSY  | master gidx owns the slave; its strobes pass straight through
module avalon_mm_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  avalon_mm_rr_arbiter_if.slave  bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   timeout_err,
  input  logic                   timeout_clr
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [GW-1:0]          gidx, gidx_nxt;
  logic [GW-1:0]          last_grant, last_nxt;
  logic [CW-1:0]          stall_cnt, stall_nxt;
  logic [NUM_MASTERS-1:0] req;
  logic [GW:0]            pick;
  logic                   cur_req;
  logic                   stalling;
  logic                   err_set;

  // First requester strictly after 'last', wrapping; MSB flags a winner.
  // Scanning from the far end and overwriting leaves the nearest one.
  function automatic logic [GW:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                          input logic [GW-1:0] last);
    logic [GW:0]   res;
    logic [GW-1:0] ix;
    int            idx;
    res = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_MASTERS;
      ix  = GW'(idx);
      if (r[ix]) res = {1'b1, ix};
    end
    return res;
  endfunction

  assign req      = bus.m_read | bus.m_write;
  assign cur_req  = req[gidx];
  assign stalling = (state == BUSY) && cur_req && bus.s_waitrequest;

  // State, grant, round-robin pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      last_grant  <= LAST_INIT;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      gidx        <= gidx_nxt;
      last_grant  <= last_nxt;
      stall_cnt   <= stall_nxt;
      timeout_err <= err_set | (timeout_err & ~timeout_clr);
    end
  end

  // Next state: arbitrate from IDLE, and again on completion with the
  // finishing master masked so a waiting master gets a back-to-back grant.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    last_nxt  = last_grant;
    pick      = '0;
    case (state)
      IDLE: begin
        pick = rr_pick(req, last_grant);
        if (pick[GW]) begin
          state_nxt = BUSY;
          gidx_nxt  = pick[GW-1:0];
          grant_nxt = NUM_MASTERS'(1) << pick[GW-1:0];
        end
      end
      BUSY: begin
        if (!cur_req) begin
          // abort: pointer left alone so the aborting master keeps its turn
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (!bus.s_waitrequest) begin
          last_nxt = gidx;
          pick     = rr_pick(req & ~grant, gidx);
          if (pick[GW]) begin
            gidx_nxt  = pick[GW-1:0];
            grant_nxt = NUM_MASTERS'(1) << pick[GW-1:0];
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Watchdog: count stalled BUSY cycles, saturate, flag while saturated.
  always_comb begin
    stall_nxt = '0;
    if (stalling) stall_nxt = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + 1'b1;
    err_set = (TIMEOUT > 0) && stalling && (stall_nxt == CNT_MAX);
  end

  // Outputs: pass the granted master through to the slave, gate the strobes.
  always_comb begin
    bus.s_address     = bus.m_address[int'(gidx)*AW +: AW];
    bus.s_writedata   = bus.m_writedata[int'(gidx)*DW +: DW];
    bus.s_read        = (state == BUSY) && bus.m_read[gidx];
    bus.s_write       = (state == BUSY) && bus.m_write[gidx] && !bus.m_read[gidx];
    bus.m_readdata    = bus.s_readdata;
    bus.m_waitrequest = '1;
    if (state == BUSY) bus.m_waitrequest[gidx] = bus.s_waitrequest;
  end

endmodule
